pipeline_ctrl: RTL and testbench

// - Stall/flush sequencer for the 5-stage RV64I pipeline; companion to the forwarding unit.
// - Resolves the hazards forwarding cannot cover: load-use, taken branch/jump, data-memory wait, halt.
// - Drives the enable/clear controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// - Keeps saturating stall and flush performance counters.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the pipeline control logic: sequencer states and
// architectural register constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear has priority over the increment.
module sat_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (clear) begin
      value_q <= '0;
    end else if (inc && (value_q != '1)) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV64I pipeline: covers load-use,
// taken branch, data-memory wait and halt, and keeps stall/flush counters.
module pipeline_ctrl
  import riscv_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rd_E,
  input  logic             MemRead_E,
  input  logic             PCSrc_E,
  input  logic             MemReq_M,
  input  logic             MemReady_M,
  input  logic             Halt_W,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_W,
  output logic             Halted,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic mem_wait;
  logic lw_stall;
  logic stall_inc;
  logic flush_inc;

  assign mem_wait = MemReq_M & ~MemReady_M;
  assign lw_stall = MemRead_E & (Rd_E != REG_X0) &
                    ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));

  // NOTE: reset is synchronous, so the state register only needs a plain
  // posedge clk sensitivity and rst is just the highest-priority branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Stall_E    = 1'b0;
    Stall_M    = 1'b0;
    Flush_D    = 1'b0;
    Flush_E    = 1'b0;
    Flush_W    = 1'b0;
    Halted     = 1'b0;

    case (state_q)
      S_INIT: begin
        Stall_F = 1'b1;
        Flush_D = 1'b1;
        Flush_E = 1'b1;
        Flush_W = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end

      S_RUN: begin
        if (mem_wait) begin
          Stall_F    = 1'b1;
          Stall_D    = 1'b1;
          Stall_E    = 1'b1;
          Stall_M    = 1'b1;
          Flush_W    = 1'b1;
          stall_inc  = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_MEM_WAIT;
        end else begin
          // A taken branch squashes Decode, so a load-use match there is moot.
          if (PCSrc_E) begin
            Flush_D   = 1'b1;
            Flush_E   = 1'b1;
            flush_inc = 1'b1;
          end else if (lw_stall) begin
            Stall_F   = 1'b1;
            Stall_D   = 1'b1;
            Flush_E   = 1'b1;
            stall_inc = 1'b1;
          end
          if (Halt_W) begin
            state_d = S_HALT;
          end
        end
      end

      S_MEM_WAIT: begin
        if (!MemReady_M) begin
          Stall_F   = 1'b1;
          Stall_D   = 1'b1;
          Stall_E   = 1'b1;
          Stall_M   = 1'b1;
          Flush_W   = 1'b1;
          stall_inc = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // The instruction in Writeback retires on the ready cycle, so a
          // halt deferred by the wait takes effect here.
          state_d = Halt_W ? S_HALT : S_RUN;
        end
      end

      S_HALT: begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Stall_M = 1'b1;
        Flush_W = 1'b1;
        Halted  = 1'b1;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign MemTimeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .value (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush_inc),
    .value (FlushCnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push their
// expected outputs; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  // Control bit order: Stall_F Stall_D Stall_E Stall_M Flush_D Flush_E Flush_W Halted MemTimeout
  localparam logic [8:0] C_IDLE    = 9'b000000000;
  localparam logic [8:0] C_INIT    = 9'b100011100;
  localparam logic [8:0] C_LU      = 9'b110001000;
  localparam logic [8:0] C_BR      = 9'b000011000;
  localparam logic [8:0] C_FRZ     = 9'b111100100;
  localparam logic [8:0] C_HALT    = 9'b111100110;
  localparam logic [8:0] C_HALT_TO = 9'b111100111;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs1_D, Rs2_D, Rd_E;
  logic        MemRead_E, PCSrc_E, MemReq_M, MemReady_M, Halt_W;
  logic        Stall_F, Stall_D, Stall_E, Stall_M;
  logic        Flush_D, Flush_E, Flush_W, Halted, MemTimeout;
  logic [63:0] StallCnt, FlushCnt;

  typedef struct {
    int          id;
    logic [8:0]  ctrl;
    logic [63:0] sc;
    logic [63:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  pipeline_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1_D      (Rs1_D),
    .Rs2_D      (Rs2_D),
    .Rd_E       (Rd_E),
    .MemRead_E  (MemRead_E),
    .PCSrc_E    (PCSrc_E),
    .MemReq_M   (MemReq_M),
    .MemReady_M (MemReady_M),
    .Halt_W     (Halt_W),
    .Stall_F    (Stall_F),
    .Stall_D    (Stall_D),
    .Stall_E    (Stall_E),
    .Stall_M    (Stall_M),
    .Flush_D    (Flush_D),
    .Flush_E    (Flush_E),
    .Flush_W    (Flush_W),
    .Halted     (Halted),
    .MemTimeout (MemTimeout),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: inputs change 1ns after the rising edge and the
  // expected response for that cycle is queued for the monitor.
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic mr, input logic pc,
                     input logic mq, input logic my, input logic hw,
                     input logic [8:0] ec, input logic [63:0] esc, input logic [63:0] efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; Rs1_D = rs1; Rs2_D = rs2; Rd_E = rd;
    MemRead_E = mr; PCSrc_E = pc; MemReq_M = mq; MemReady_M = my; Halt_W = hw;
    e.id = step_id; e.ctrl = ec; e.sc = esc; e.fc = efc;
    exp_q.push_back(e);
    step_id++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("ctrl@%0d", e.id),
            {55'd0, Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, Halted, MemTimeout},
            {55'd0, e.ctrl});
      check($sformatf("stallcnt@%0d", e.id), StallCnt, e.sc);
      check($sformatf("flushcnt@%0d", e.id), FlushCnt, e.fc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Rs1_D = '0; Rs2_D = '0; Rd_E = '0;
    MemRead_E = 1'b0; PCSrc_E = 1'b0; MemReq_M = 1'b0; MemReady_M = 1'b0; Halt_W = 1'b0;

    // Reset for two edges, then exactly four flush cycles before RUN.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);

    // Load-use on Rs2, then load-use masked by a taken branch.
    cyc(0, 0, 5, 5, 1, 0, 0, 0, 0, C_LU,   0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 0);
    cyc(0, 0, 5, 5, 1, 1, 0, 0, 0, C_BR,   1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 1, 1);

    // x0 never creates a hazard; load-use on Rs1; same match without a load.
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, C_IDLE, 1, 1);
    cyc(0, 7, 3, 7, 1, 0, 0, 0, 0, C_LU,   1, 1);
    cyc(0, 7, 3, 7, 0, 0, 0, 0, 0, C_IDLE, 2, 1);

    // Three wait cycles with a branch pulse inside, then ready.
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ,  2, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, C_FRZ,  3, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ,  4, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, C_IDLE, 5, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 5, 1);

    // Halt retires, then the pipeline freezes and ignores hazards.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, C_IDLE, 5, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_HALT, 5, 1);
    cyc(0, 0, 5, 5, 1, 1, 0, 0, 0, C_HALT, 5, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_HALT, 5, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_IDLE, 0, 0);

    // Memory never ready: one RUN cycle plus 255 wait cycles, then halt.
    for (int i = 0; i < 256; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ, 64'(i), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, C_HALT_TO, 256, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, C_HALT_TO, 256, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, C_HALT_TO, 256, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, C_INIT, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
